embnew16k_nios2_jtag_debug_cmd_decoder: RTL
===========================================

# embnew16k_nios2_jtag_debug_cmd_decoder

Parametrised system-clock-side command decoder for the Nios II JTAG debug module. It takes the update strobes, instruction register and captured shift register from the TCK-domain logic and synchronises the strobes into `clk`. Each completed JTAG update is queued in a small command FIFO, then popped under a valid/ready handshake into `jdo` and a one-hot action pulse. It generalises the fixed 2-bit-IR / 38-bit-SR sysclk stage: IR width, SR width, synchroniser depth and queue depth are parameters, and it adds buffering, backpressure and overflow reporting.

## Interface
Parameters:
- `SR_W`, 38, width of shift register `sr` and of `jdo`
- `IR_W`, 2, width of `ir_in`; number of action channels `NCH` = 2**IR_W
- `ACT_BIT`, 37, index of the `sr` bit that selects take_action (1) vs take_no_action (0)
- `SYNC_STAGES`, 2, flops per strobe synchroniser, legal range 2..4
- `DEPTH`, 4, command FIFO entries, power of two, legal range 2..16

Ports:
- `clk`  in  1  system clock; all state is in this domain
- `reset_n`  in  1  asynchronous active-low reset
- `vs_udr`  in  1  virtual-state update-DR from the TCK domain; asynchronous to `clk`; level held at least SYNC_STAGES+1 `clk` periods
- `vs_uir`  in  1  virtual-state update-IR from the TCK domain; asynchronous, same hold rule
- `ir_in`  in  IR_W  current instruction; quasi-static while the synchronised strobe is high
- `sr`  in  SR_W  captured data register; quasi-static while the synchronised `vs_udr` is high
- `cmd_ready`  in  1  consumer accepts the head entry this cycle
- `clr_ovf`  in  1  synchronous clear of `overflow`
- `cmd_valid`  out  1  FIFO non-empty
- `cmd_kind`  out  1  head entry type: 1 = DR update, 0 = IR update
- `cmd_ir`  out  IR_W  IR code of the head entry
- `cmd_count`  out  $clog2(DEPTH+1)  occupancy
- `jdo`  out  SR_W  data of the last popped DR-update entry
- `take_action`  out  NCH  one-cycle one-hot pulse per IR channel
- `take_no_action`  out  NCH  one-cycle one-hot pulse per IR channel
- `overflow`  out  1  sticky; set when an update is dropped

## Operation
- Synchronisers: `vs_udr` and `vs_uir` each pass through a SYNC_STAGES-flop chain, plus one history flop. A rising edge is `sync & ~hist`. Only rising edges matter; a falling edge does nothing.
- Enqueue on a udr edge: write {kind=1, ir_in, sr}.
- Enqueue on a uir edge: write {kind=0, ir_in, sr=0}.
- `ir_in` and `sr` are sampled directly (not synchronised) in the edge cycle.
- Both edges in the same cycle: enqueue udr only, drop uir, set `overflow`.
- FIFO full, no pop, edge detected: drop the new entry, set `overflow`, keep FIFO contents.
- FIFO full with a simultaneous pop (`cmd_valid & cmd_ready`) and edge: accept the write; count stays DEPTH.
- Pop (`cmd_valid & cmd_ready`):
  - kind=1: load `jdo` <= entry sr. If sr[ACT_BIT]=1, pulse `take_action[ir]`; otherwise pulse `take_no_action[ir]`.
  - kind=0: `jdo` unchanged, no pulse.
- `cmd_ready` while empty: ignored.
- Push and pop in the same cycle: count unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from `cmd_count`.
- `overflow` set has priority over `clr_ovf` in the same cycle.
- Reset (asynchronous, any time, including mid-queue): synchronisers, history flops, pointers and count go to 0, and all outputs go to 0. Queued entries are discarded.

## Timing
- Strobe latency: a `vs_udr` rise first sampled at clk edge k gives an entry written at edge k+SYNC_STAGES. `cmd_valid` rises in the cycle after that edge (SYNC_STAGES+1 edges total with an empty FIFO).
- `cmd_kind`/`cmd_ir` show the head entry combinationally from FIFO storage while `cmd_valid`=1.
- Pop at edge m: `jdo` and the action pulse update at edge m. The pulse is high for exactly one cycle, and `cmd_count` decrements at edge m.
- Back-to-back pops deliver one entry per cycle.
- Throughput: at most one entry per `clk` cycle; the strobe hold rule guarantees a single edge per update.

## Test plan
- Single DR update: IR_W=2, ir_in=2, sr[37]=1, sr[31:0]=32'hCAFE_0001, pulse `vs_udr`, `cmd_ready`=1 -> `cmd_valid` 3 edges after first sample; `jdo`=that sr; `take_action`=4'b0100 for one cycle.
- No-action path: ir_in=1, sr[37]=0 -> `take_no_action`=4'b0010 once; `take_action` stays 0; `jdo` loaded.
- Overflow: `cmd_ready`=0, five DR updates with DEPTH=4 -> `cmd_count`=4, `overflow`=1. Draining yields the first four sr values in order; the fifth is lost. `clr_ovf` -> `overflow`=0.
- IR update: pulse `vs_uir` with ir_in=3 -> one entry, `cmd_kind`=0, `cmd_ir`=3. Pop gives no pulse and `jdo` is unchanged.
- Full plus simultaneous pop and push: FIFO full, `cmd_ready`=1 in the edge cycle -> count stays 4, `overflow` stays 0, the new entry is at the tail.
- Reset mid-operation: 3 entries queued, assert `reset_n`=0 asynchronously -> `cmd_valid`, `cmd_count`, `jdo` and all pulses are 0 immediately. After release, no stale entries appear.

Source files
------------

// File: rtl/embnew16k_nios2_jtag_debug_cmd_decoder.sv
// rtl/embnew16k_nios2_jtag_debug_cmd_decoder.sv - sysclk-side JTAG debug command decoder
// Synchronises TCK-domain update strobes, queues commands, pops into jdo plus a one-hot action pulse.
module embnew16k_nios2_jtag_debug_cmd_decoder #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 37,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    localparam int NCH        = 2 ** IR_W,
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vs_udr,
    input  logic            vs_uir,
    input  logic [IR_W-1:0] ir_in,
    input  logic [SR_W-1:0] sr,
    input  logic            cmd_ready,
    input  logic            clr_ovf,
    output logic            cmd_valid,
    output logic            cmd_kind,
    output logic [IR_W-1:0] cmd_ir,
    output logic [CW-1:0]   cmd_count,
    output logic [SR_W-1:0] jdo,
    output logic [NCH-1:0]  take_action,
    output logic [NCH-1:0]  take_no_action,
    output logic            overflow
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_hist;
    logic                   r_uir_hist;

    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic [SR_W-1:0]        r_jdo;
    logic [NCH-1:0]         r_take_action;
    logic [NCH-1:0]         r_take_no_action;

    logic                   r_mem_kind [DEPTH];
    logic [IR_W-1:0]        r_mem_ir   [DEPTH];
    logic [SR_W-1:0]        r_mem_sr   [DEPTH];

    logic                   w_udr_rise;
    logic                   w_uir_rise;
    logic                   w_push_req;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_wr_kind;
    logic [SR_W-1:0]        w_wr_sr;
    logic                   w_head_kind;
    logic [IR_W-1:0]        w_head_ir;
    logic [SR_W-1:0]        w_head_sr;
    logic [NCH-1:0]         w_head_onehot;

    // Edge detect after the synchroniser; only rising edges create commands.
    assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_hist;
    assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_hist;
    assign w_push_req = w_udr_rise | w_uir_rise;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & cmd_ready;

    // A full queue still accepts a write when the head leaves in the same cycle.
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = (w_udr_rise & w_uir_rise) | (w_push_req & w_full & ~w_pop);

    assign w_wr_kind = w_udr_rise;
    assign w_wr_sr   = w_udr_rise ? sr : '0;

    assign w_head_kind   = r_mem_kind[r_rd_ptr];
    assign w_head_ir     = r_mem_ir[r_rd_ptr];
    assign w_head_sr     = r_mem_sr[r_rd_ptr];
    assign w_head_onehot = NCH'(1) << w_head_ir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_udr_sync <= '0;
            r_uir_sync <= '0;
            r_udr_hist <= 1'b0;
            r_uir_hist <= 1'b0;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_hist <= r_udr_sync[SYNC_STAGES-1];
            r_uir_hist <= r_uir_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_kind[r_wr_ptr] <= w_wr_kind;
            r_mem_ir[r_wr_ptr]   <= ir_in;
            r_mem_sr[r_wr_ptr]   <= w_wr_sr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Setting wins over clearing so a drop in the clear cycle is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jdo            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
            if (w_pop && w_head_kind) begin
                r_jdo <= w_head_sr;
                if (w_head_sr[ACT_BIT]) begin
                    r_take_action <= w_head_onehot;
                end else begin
                    r_take_no_action <= w_head_onehot;
                end
            end
        end
    end

    assign cmd_valid      = ~w_empty;
    assign cmd_kind       = ~w_empty & w_head_kind;
    assign cmd_ir         = w_empty ? '0 : w_head_ir;
    assign cmd_count      = r_count;
    assign jdo            = r_jdo;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign overflow       = r_overflow;

endmodule
